// File: rtl/calc_port_responder.sv
// Device end of the calculator request/response protocol: takes a command plus
// two operands on consecutive cycles and returns a coded result LATENCY cycles later.
module calc_port_responder #(
  parameter int LATENCY = 3  // legal range 1..8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [0:0]  o_dbg_state
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OPND2 = 1'b1;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_OVF  = 2'b10;
  localparam logic [1:0] RESP_INV  = 2'b11;

  // Handshake: there is no ready. A nonzero req_cmd_in in IDLE is an accepted
  // command, and the next cycle's req_data_in is taken as operand2 regardless
  // of req_cmd_in. The response is a one-cycle pulse with no back-pressure.

  logic [0:0]  r_state;
  logic [3:0]  r_cmd;
  logic [31:0] r_op1;

  logic [LATENCY-1:0] r_pipe_valid;
  logic [1:0]         r_pipe_resp [LATENCY];
  logic [31:0]        r_pipe_data [LATENCY];

  logic        r_out_valid;
  logic [1:0]  r_out_resp;
  logic [31:0] r_out_data;

  logic [32:0] w_sum;
  logic [31:0] w_diff;
  logic [4:0]  w_shamt;
  logic [1:0]  w_result_resp;
  logic [31:0] w_result_data;
  logic        w_push;

  assign w_sum   = {1'b0, r_op1} + {1'b0, req_data_in};
  assign w_diff  = r_op1 - req_data_in;
  assign w_shamt = req_data_in[4:0];
  assign w_push  = (r_state == S_OPND2);

  always_comb begin
    w_result_resp = RESP_INV;
    w_result_data = 32'd0;
    case (r_cmd)
      CMD_ADD: begin
        if (w_sum[32]) begin
          w_result_resp = RESP_OVF;
        end else begin
          w_result_resp = RESP_OK;
          w_result_data = w_sum[31:0];
        end
      end
      CMD_SUB: begin
        if (req_data_in > r_op1) begin
          w_result_resp = RESP_OVF;
        end else begin
          w_result_resp = RESP_OK;
          w_result_data = w_diff;
        end
      end
      CMD_SHL: begin
        w_result_resp = RESP_OK;
        w_result_data = r_op1 << w_shamt;
      end
      CMD_SHR: begin
        w_result_resp = RESP_OK;
        w_result_data = r_op1 >> w_shamt;
      end
      default: begin
        w_result_resp = RESP_INV;
        w_result_data = 32'd0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_NOP;
      r_op1   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_cmd_in != CMD_NOP) begin
            r_cmd   <= req_cmd_in;
            r_op1   <= req_data_in;
            r_state <= S_OPND2;
          end
        end
        S_OPND2: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage 0 is loaded on the operand2 edge; the output register adds the final cycle.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_resp[i] <= RESP_NONE;
        r_pipe_data[i] <= 32'd0;
      end
    end else begin
      r_pipe_valid[0] <= w_push;
      r_pipe_resp[0]  <= w_result_resp;
      r_pipe_data[0]  <= w_result_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_resp[i]  <= r_pipe_resp[i-1];
        r_pipe_data[i]  <= r_pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_resp  <= RESP_NONE;
      r_out_data  <= 32'd0;
    end else begin
      r_out_valid <= r_pipe_valid[LATENCY-1];
      if (r_pipe_valid[LATENCY-1]) begin
        r_out_resp <= r_pipe_resp[LATENCY-1];
        r_out_data <= r_pipe_data[LATENCY-1];
      end else begin
        r_out_resp <= RESP_NONE;
        r_out_data <= 32'd0;
      end
    end
  end

  // busy covers the response cycle too, so it drops the cycle after emission.
  assign busy        = (r_state == S_OPND2) | (|r_pipe_valid) | r_out_valid;
  assign out_resp    = r_out_resp;
  assign out_data    = r_out_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: reset, each opcode, overflow edges,
// invalid and no-op commands, back-to-back issue and reset mid-pipeline.
module tb_calc_port_responder;

  localparam int LAT = 3;

  logic        c_clk;
  logic        rst_n;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        busy;
  logic [0:0]  dbg_state;

  int tests_run;
  int tests_failed;

  calc_port_responder #(.LATENCY(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (rst_n),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock/reset block
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, " resp"}, {30'd0, out_resp}, 32'd0);
    chk({tag, " data"}, out_data, 32'd0);
  endtask

  // One complete operation; operand2 cycle carries a nonzero cmd that must be ignored.
  task automatic do_op(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [1:0] exp_resp,
                       input logic [31:0] exp_data);
    req_cmd_in  = cmd;
    req_data_in = op1;
    step();
    chk({tag, " busy_rise"}, {31'd0, busy}, 32'd1);
    req_cmd_in  = 4'hF;
    req_data_in = op2;
    step();
    req_cmd_in  = 4'd0;
    req_data_in = 32'd0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT) begin
        chk({tag, " early"}, {30'd0, out_resp}, 32'd0);
      end else begin
        chk({tag, " resp"}, {30'd0, out_resp}, {30'd0, exp_resp});
        chk({tag, " data"}, out_data, exp_data);
        chk({tag, " busy_resp"}, {31'd0, busy}, 32'd1);
      end
    end
    step();
    chk_idle_out({tag, " after"});
    chk({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req_cmd_in   = 4'd0;
    req_data_in  = 32'd0;

    for (int c = 0; c < 7; c++) begin
      step();
      chk_idle_out("reset");
      chk("reset busy", {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle_out("post_reset");
      chk("post_reset busy", {31'd0, busy}, 32'd0);
    end

    do_op("add",      4'd1, 32'h64,       32'h27,       2'b01, 32'h8B);
    do_op("add_ovf",  4'd1, 32'hFFFF_FFFF, 32'h1,       2'b10, 32'h0);
    do_op("add_max",  4'd1, 32'hFFFF_FFFE, 32'h1,       2'b01, 32'hFFFF_FFFF);
    do_op("sub_unf",  4'd2, 32'h22,       32'h23,       2'b10, 32'h0);
    do_op("sub_eq",   4'd2, 32'h5,        32'h5,        2'b01, 32'h0);
    do_op("sub",      4'd2, 32'h1000,     32'h1,        2'b01, 32'hFFF);
    do_op("shl",      4'd5, 32'h3,        32'h22,       2'b01, 32'hC);
    do_op("shl_lost", 4'd5, 32'h8000_0001, 32'h1,       2'b01, 32'h2);
    do_op("shr",      4'd6, 32'hC,        32'h2,        2'b01, 32'h3);
    do_op("shr_log",  4'd6, 32'h8000_0000, 32'h3F,      2'b01, 32'h1);
    do_op("inv9",     4'd9, 32'h1234,     32'h5678,     2'b11, 32'h0);
    do_op("inv3",     4'd3, 32'h1,        32'h1,        2'b11, 32'h0);

    // cmd 0 never starts anything
    for (int c = 0; c < LAT + 4; c++) begin
      req_cmd_in  = 4'd0;
      req_data_in = $urandom_range(1, 1000);
      step();
      chk_idle_out("nop");
      chk("nop busy", {31'd0, busy}, 32'd0);
    end
    req_data_in = 32'd0;

    // back-to-back: add 5+1 at c=0, sub 5-2 at c=2
    for (int c = 0; c <= LAT + 5; c++) begin
      case (c)
        0: begin req_cmd_in = 4'd1; req_data_in = 32'd5; end
        1: begin req_cmd_in = 4'd0; req_data_in = 32'd1; end
        2: begin req_cmd_in = 4'd2; req_data_in = 32'd5; end
        3: begin req_cmd_in = 4'd0; req_data_in = 32'd2; end
        default: begin req_cmd_in = 4'd0; req_data_in = 32'd0; end
      endcase
      step();
      if (c == LAT + 1) begin
        chk("b2b first resp", {30'd0, out_resp}, 32'd1);
        chk("b2b first data", out_data, 32'd6);
      end else if (c == LAT + 3) begin
        chk("b2b second resp", {30'd0, out_resp}, 32'd1);
        chk("b2b second data", out_data, 32'd3);
      end else begin
        chk_idle_out("b2b gap");
      end
      chk("b2b busy", {31'd0, busy}, (c <= LAT + 3) ? 32'd1 : 32'd0);
    end

    // same traffic, reset low for the edge after the second op2: nothing emerges
    for (int c = 0; c <= LAT + 6; c++) begin
      case (c)
        0: begin req_cmd_in = 4'd1; req_data_in = 32'd5; end
        1: begin req_cmd_in = 4'd0; req_data_in = 32'd1; end
        2: begin req_cmd_in = 4'd2; req_data_in = 32'd5; end
        3: begin req_cmd_in = 4'd0; req_data_in = 32'd2; end
        default: begin req_cmd_in = 4'd0; req_data_in = 32'd0; end
      endcase
      rst_n = (c == 4) ? 1'b0 : 1'b1;
      step();
      chk_idle_out("rst_mid");
      chk("rst_mid busy", {31'd0, busy}, (c <= 3) ? 32'd1 : 32'd0);
    end
    rst_n = 1'b1;

    // reset in the operand2 cycle discards the op
    req_cmd_in  = 4'd1;
    req_data_in = 32'd7;
    step();
    rst_n       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = 32'd9;
    step();
    rst_n = 1'b1;
    req_data_in = 32'd0;
    for (int c = 0; c < LAT + 3; c++) begin
      step();
      chk_idle_out("rst_op2");
      chk("rst_op2 busy", {31'd0, busy}, 32'd0);
    end

    do_op("after_rst", 4'd1, 32'h10, 32'h20, 2'b01, 32'h30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
Name: calc_port_responder

Overview:
- Single-channel calculator responder: the device end of the request/response protocol that the calculator bench drives.
- Accepts a command with operand1, then operand2 on the following cycle. Computes add, subtract, shift left or shift right, and returns a one-cycle response code with 32-bit data after a fixed latency.
- Four instances plus arbitration make up the multi-port calculator top.

Parameters:
- LATENCY, 3, cycles from the operand2 sampling edge to the edge that drives the response; legal range 1..8.

Ports:
- c_clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge c_clk.
- req_cmd_in  input  4  command, valid in the operand1 cycle: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr, others invalid.
- req_data_in  input  32  operand1 in the command cycle, operand2 in the next cycle.
- out_resp  output  2  00 none, 01 success, 10 overflow/underflow, 11 invalid command.
- out_data  output  32  result when out_resp=01, else 0.
- busy  output  1  high while an operation is in flight (operand2 pending or result in pipeline).

Behaviour:
- Reset (reset=0 at posedge):
  - out_resp=0, out_data=0, busy=0.
  - FSM goes to IDLE and all pipeline stages are invalidated.
  - In-flight operations are discarded and produce no response, including reset asserted in the operand2 cycle.
- FSM states:
  - IDLE: a nonzero cmd sampled latches cmd and operand1, then goes to OPND2. cmd=0 stays IDLE with no response.
  - OPND2: the next edge samples operand2 unconditionally; req_cmd_in is ignored this cycle, even if nonzero. Result is computed and pushed into the pipeline; returns to IDLE.
- Timing:
  - Operand1 is sampled at edge T and operand2 at edge T+1.
  - out_resp/out_data are driven by edge T+1+LATENCY and held exactly one cycle. They return to 00/0 at the next edge unless another result is due.
- Throughput:
  - A new command may be presented at edge T+2 (back-to-back), giving one op per 2 cycles.
  - The pipeline is a LATENCY-deep shift register of {valid, resp, data}, so overlapping ops never stall or drop.
  - Responses leave in issue order.
- Arithmetic (unsigned 32-bit):
  - add: 33-bit sum; carry=1 gives resp 10, data 0; else resp 01, data = sum[31:0].
  - sub: op1 - op2; op2 > op1 gives resp 10, data 0; else resp 01, data = difference. op1 == op2 gives resp 01, data 0.
  - shl: op1 << op2[4:0]; resp 01. Upper bits of op2 are ignored and bits shifted out are lost, never overflow.
  - shr: op1 >> op2[4:0], logical; resp 01.
  - cmd 3, 4, 7..15: resp 11, data 0. Still consumes the operand2 cycle and still honours LATENCY.
- busy:
  - Rises the cycle after a nonzero cmd is accepted.
  - Falls the cycle after the last valid pipeline entry is emitted.
  - Stays high continuously under back-to-back traffic.
- Reset mid-pipeline clears valids, so no stale response appears after reset deassertion.

Test Plan:
- Reset held low 7 cycles, then released; no commands sent -> out_resp=00, out_data=0, busy=0 throughout.
- cmd=1, op1=0x64, op2=0x27 -> exactly LATENCY cycles after the op2 edge: resp=01, data=0x8B for one cycle, then 00/0.
- cmd=1, op1=0xFFFFFFFF, op2=0x1 -> resp=10, data=0. cmd=2, op1=0x22, op2=0x23 -> resp=10, data=0. cmd=2, op1=5, op2=5 -> resp=01, data=0.
- cmd=5, op1=3, op2=0x22 (shift 2) -> resp=01, data=0xC. cmd=6, op1=0xC, op2=2 -> resp=01, data=0x3.
- cmd=9 with any operands -> resp=11, data=0 at the normal latency. cmd=0 -> no response ever, busy stays 0.
- Back-to-back add (5+1) then sub (5-2) issued at T and T+2 -> responses 01/6 and 01/3 on consecutive-by-2 cycles in order. Repeat with reset pulsed low one cycle after the second op2 -> no responses emitted.
